pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 80 ++++++++
 tb/tb_pc_fetch_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch stage: offers pc downstream with a valid/ready handshake,
// supports redirect (load) and halt, and counts accepted fetches with saturation.
module pc_fetch_unit #(
  parameter logic [15:0] RESET_VEC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] din,
  input  logic        halt,
  input  logic        ready,
  output logic [15:0] pc,
  output logic        valid,
  output logic [15:0] pc_inc,
  output logic        wrap,
  output logic [15:0] fetch_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        wrap_q, wrap_d;
  logic        transfer;

  assign pc        = pc_q;
  assign pc_inc    = pc_q + 16'd1;
  assign valid     = (state_q == RUN);
  assign wrap      = wrap_q;
  assign fetch_cnt = cnt_q;
  assign transfer  = valid & ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      cnt_q   <= 16'h0000;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wrap_d  = 1'b0;
    // Any accepted transfer counts, including load and halt cycles.
    cnt_d   = (transfer && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (load) begin
          pc_d = din;
        end else if (halt) begin
          state_d = HALT;
        end else if (transfer) begin
          pc_d   = pc_inc;
          wrap_d = (pc_q == 16'hFFFF);
        end
      end
      HALT: begin
        if (load) begin
          pc_d    = din;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: boot, stall, wrap, halt/resume, load
// priority, async reset aborts and fetch counter saturation.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] din;
  logic        halt;
  logic        ready;
  logic [15:0] pc;
  logic        valid;
  logic [15:0] pc_inc;
  logic        wrap;
  logic [15:0] fetch_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  pc_fetch_unit #(.RESET_VEC(16'h0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .din       (din),
    .halt      (halt),
    .ready     (ready),
    .pc        (pc),
    .valid     (valid),
    .pc_inc    (pc_inc),
    .wrap      (wrap),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] e_pc, input logic e_valid,
                            input logic e_wrap, input logic [15:0] e_cnt);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".valid"}, {15'd0, valid}, {15'd0, e_valid});
    check({tag, ".wrap"}, {15'd0, wrap}, {15'd0, e_wrap});
    check({tag, ".cnt"}, fetch_cnt, e_cnt);
    $display("txn %-12s pc=%h valid=%b wrap=%b cnt=%h", tag, pc, valid, wrap, fetch_cnt);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; din = 16'h0000; halt = 1'b0; ready = 1'b1;
    #12;
    expect_out("reset", 16'h0000, 1'b0, 1'b0, 16'h0000);
    reset = 1'b0;
    #1;
    expect_out("boot", 16'h0000, 1'b0, 1'b0, 16'h0000);
    // load/halt ignored in BOOT
    load = 1'b1; din = 16'h1234; halt = 1'b1;
    step;
    load = 1'b0; halt = 1'b0;
    expect_out("run0", 16'h0000, 1'b1, 1'b0, 16'h0000);
    step;
    expect_out("run1", 16'h0001, 1'b1, 1'b0, 16'h0001);
    step;
    expect_out("run2", 16'h0002, 1'b1, 1'b0, 16'h0002);
    check("pc_inc2", pc_inc, 16'h0003);

    // stall: redirect to 0x0010 without acceptance, then hold 3 cycles
    load = 1'b1; din = 16'h0010; ready = 1'b0;
    step;
    load = 1'b0;
    expect_out("ld10", 16'h0010, 1'b1, 1'b0, 16'h0002);
    for (int i = 0; i < 3; i++) begin
      step;
      expect_out("stall", 16'h0010, 1'b1, 1'b0, 16'h0002);
    end
    ready = 1'b1;
    step;
    expect_out("accept", 16'h0011, 1'b1, 1'b0, 16'h0003);

    // load with transfer counts old pc; then wrap
    load = 1'b1; din = 16'hFFFF;
    step;
    load = 1'b0;
    expect_out("ldFFFF", 16'hFFFF, 1'b1, 1'b0, 16'h0004);
    step;
    expect_out("wrap", 16'h0000, 1'b1, 1'b1, 16'h0005);
    check("pc_inc_w", pc_inc, 16'h0001);
    ready = 1'b0;
    step;
    expect_out("wrapend", 16'h0000, 1'b1, 1'b0, 16'h0005);
    load = 1'b1; din = 16'hFFFF;
    step;
    expect_out("ldFFFF2", 16'hFFFF, 1'b1, 1'b0, 16'h0005);
    din = 16'h0000; ready = 1'b1;
    step;
    load = 1'b0; ready = 1'b0;
    expect_out("ld0nowrap", 16'h0000, 1'b1, 1'b0, 16'h0006);

    // halt with transfer, halt release alone, resume by load
    load = 1'b1; din = 16'h0020;
    step;
    load = 1'b0; halt = 1'b1; ready = 1'b1;
    expect_out("ld20", 16'h0020, 1'b1, 1'b0, 16'h0006);
    step;
    halt = 1'b0;
    expect_out("halt", 16'h0020, 1'b0, 1'b0, 16'h0007);
    step;
    expect_out("halted", 16'h0020, 1'b0, 1'b0, 16'h0007);
    load = 1'b1; din = 16'h0100;
    step;
    load = 1'b0; ready = 1'b0;
    expect_out("resume", 16'h0100, 1'b1, 1'b0, 16'h0007);

    // load beats halt
    load = 1'b1; halt = 1'b1; din = 16'h0300; ready = 1'b1;
    step;
    load = 1'b0; halt = 1'b0; ready = 1'b0;
    expect_out("ldhalt", 16'h0300, 1'b1, 1'b0, 16'h0008);

    // async reset in the middle of HALT
    halt = 1'b1;
    step;
    halt = 1'b0;
    expect_out("halt2", 16'h0300, 1'b0, 1'b0, 16'h0008);
    #2 reset = 1'b1;
    #1;
    expect_out("rst_halt", 16'h0000, 1'b0, 1'b0, 16'h0000);
    reset = 1'b0;
    step;
    expect_out("reboot", 16'h0000, 1'b1, 1'b0, 16'h0000);

    // 65535 transfers fill the counter; one more must saturate
    ready = 1'b1;
    for (int i = 0; i < 65535; i++) step;
    expect_out("cntmax", 16'hFFFF, 1'b1, 1'b0, 16'hFFFF);
    step;
    expect_out("saturate", 16'h0000, 1'b1, 1'b1, 16'hFFFF);
    #2 reset = 1'b1;
    #1;
    expect_out("rst_mid", 16'h0000, 1'b0, 1'b0, 16'h0000);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
